// File: rtl/unary_pkg.sv
// unary_pkg -- shared definitions for the unary stream transmitter.
//
// Holds the frame FSM state encoding and the default geometry constants
// (stream length and number of write-phase cycles) used as parameter
// defaults by unary_stream_tx and unary_therm_bit.
package unary_pkg;

   localparam int DEF_LEN       = 16;
   localparam int DEF_WR_CYCLES = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/unary_therm_bit.sv
// unary_therm_bit -- one thermometer-code bit generator.
//
// Produces bit number idx of a thermometer stream whose length is val,
// saturated to LEN, so an operand above LEN still yields exactly LEN ones.
//
// Ports:
//   idx       in  CW  position in the stream (0 .. LEN-1)
//   val       in  CW  binary operand (may exceed LEN)
//   therm_bit out 1   (idx < min(val, LEN))
module unary_therm_bit
   import unary_pkg::*;
#(
   parameter int LEN = DEF_LEN,
   parameter int CW  = $clog2(LEN + 1)
) (
   input  logic [CW-1:0] idx,
   input  logic [CW-1:0] val,
   output logic          therm_bit
);

   localparam logic [CW-1:0] LEN_C = CW'(LEN);

   logic [CW-1:0] val_sat_s;

   assign val_sat_s = (val > LEN_C) ? LEN_C : val;
   assign therm_bit = (idx < val_sat_s);

endmodule

// File: rtl/unary_stream_tx.sv
// unary_stream_tx -- converts a pair of binary operands into two
// thermometer-coded (unary) streams of LEN bits, followed by WR_CYCLES
// write-phase cycles and a one-cycle done pulse.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   in_valid       in   operand pair offered (taken only while in_ready)
//   a_val, b_val   in   CW-bit binary operands, saturated to LEN
//   in_ready       out  high only in IDLE (decoded from state)
//   hold           in   stall request while streaming
//   A, B           out  registered thermometer stream bits
//   en             out  registered adder enable
//   read_or_write  out  registered phase select (1 = write phase)
//   done           out  registered one-cycle completion pulse
//   ovf            out  only with UNARY_STREAM_TX_OVF_EN defined: operand
//                       overflow flag, latched at capture
//
// Every output except in_ready is a register that holds what the stream
// shows in the *current* cycle; the combinational block decides what the
// next cycle shows. idx_r therefore counts stream bits already emitted, and
// the first bit is loaded at the accepting edge itself (latency 1).
module unary_stream_tx
   import unary_pkg::*;
#(
   parameter  int LEN       = DEF_LEN,
   parameter  int WR_CYCLES = DEF_WR_CYCLES,
   localparam int CW        = $clog2(LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [CW-1:0] a_val,
   input  logic [CW-1:0] b_val,
   output logic          in_ready,
   input  logic          hold,
   output logic          A,
   output logic          B,
   output logic          en,
   output logic          read_or_write,
`ifdef UNARY_STREAM_TX_OVF_EN
   output logic          done,
   output logic          ovf
`else
   output logic          done
`endif
);

   localparam int             WCW     = $clog2(WR_CYCLES + 1);
   localparam logic [CW-1:0]  LEN_C   = CW'(LEN);
   localparam logic [CW-1:0]  IDX_ONE = CW'(1);
   localparam logic [WCW-1:0] WR_C    = WCW'(WR_CYCLES);
   localparam logic [WCW-1:0] WR_ONE  = WCW'(1);

   state_t         state_r, state_s;
   logic [CW-1:0]  idx_r, idx_s;
   logic [WCW-1:0] wcnt_r, wcnt_s;
   logic [CW-1:0]  a_q_r, a_q_s;
   logic [CW-1:0]  b_q_r, b_q_s;
   logic           a_r, a_s;
   logic           b_r, b_s;
   logic           en_r, en_s;
   logic           rw_r, rw_s;
   logic           done_r, done_s;
   logic           accept_s;
   logic [CW-1:0]  therm_idx_s;
   logic [CW-1:0]  a_src_s;
   logic [CW-1:0]  b_src_s;
   logic           therm_a_s;
   logic           therm_b_s;

   assign in_ready = (state_r == ST_IDLE);
   assign accept_s = in_ready && in_valid;

   // In IDLE the comparators look at the live operands so bit 0 can be
   // loaded at the accepting edge; afterwards they use the captured copies.
   assign therm_idx_s = (state_r == ST_STREAM) ? idx_r : {CW{1'b0}};
   assign a_src_s     = (state_r == ST_IDLE) ? a_val : a_q_r;
   assign b_src_s     = (state_r == ST_IDLE) ? b_val : b_q_r;

   unary_therm_bit #(.LEN(LEN), .CW(CW)) u_therm_a (
      .idx       (therm_idx_s),
      .val       (a_src_s),
      .therm_bit (therm_a_s)
   );

   unary_therm_bit #(.LEN(LEN), .CW(CW)) u_therm_b (
      .idx       (therm_idx_s),
      .val       (b_src_s),
      .therm_bit (therm_b_s)
   );

   // Next-state and next-output decode for the frame FSM
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      wcnt_s  = wcnt_r;
      a_q_s   = a_q_r;
      b_q_s   = b_q_r;
      a_s     = 1'b0;
      b_s     = 1'b0;
      en_s    = 1'b0;
      rw_s    = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               a_q_s   = a_val;
               b_q_s   = b_val;
               a_s     = therm_a_s;
               b_s     = therm_b_s;
               en_s    = 1'b1;
               idx_s   = IDX_ONE;
               state_s = ST_STREAM;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            // All LEN bits emitted: hold no longer matters, start writing.
            if (idx_r >= LEN_C) begin
               en_s    = 1'b1;
               rw_s    = 1'b1;
               wcnt_s  = WR_ONE;
               state_s = ST_WRITE;
            end else if (hold) begin
               // Stall cycle: outputs quiet, idx frozen so no bit is lost.
               idx_s = idx_r;
            end else begin
               a_s   = therm_a_s;
               b_s   = therm_b_s;
               en_s  = 1'b1;
               idx_s = idx_r + IDX_ONE;
            end
         end
         ST_WRITE: begin
            if (wcnt_r >= WR_C) begin
               done_s  = 1'b1;
               state_s = ST_DONE;
            end else begin
               en_s   = 1'b1;
               rw_s   = 1'b1;
               wcnt_s = wcnt_r + WR_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters, operand and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         idx_r   <= {CW{1'b0}};
         wcnt_r  <= {WCW{1'b0}};
         a_q_r   <= {CW{1'b0}};
         b_q_r   <= {CW{1'b0}};
         a_r     <= 1'b0;
         b_r     <= 1'b0;
         en_r    <= 1'b0;
         rw_r    <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         wcnt_r  <= wcnt_s;
         a_q_r   <= a_q_s;
         b_q_r   <= b_q_s;
         a_r     <= a_s;
         b_r     <= b_s;
         en_r    <= en_s;
         rw_r    <= rw_s;
         done_r  <= done_s;
      end
   end

   assign A             = a_r;
   assign B             = b_r;
   assign en            = en_r;
   assign read_or_write = rw_r;
   assign done          = done_r;

`ifdef UNARY_STREAM_TX_OVF_EN
   logic ovf_r;

   // Overflow flag: latched with every operand capture, held until the next
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (accept_s) begin
         ovf_r <= (a_val > LEN_C) || (b_val > LEN_C);
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_unary_stream_tx.sv
// tb_unary_stream_tx -- scoreboard bench for unary_stream_tx.
//
// A driver issues frames and, cycle by cycle, pushes the output word the
// DUT must show after the coming clock edge. The expected frame is built
// from the stream rules directly: min(val,LEN) leading ones per stream,
// stall cycles inserted where hold is requested, WR write cycles, one done
// cycle. A monitor on the falling edge pops and compares each word.
// Define UNARY_STREAM_TX_OVF_EN to also check the ovf port.
module tb_unary_stream_tx;

   localparam int LEN = 16;
   localparam int WR  = 32;
   localparam int CW  = $clog2(LEN + 1);

   typedef struct packed {
      logic a;
      logic b;
      logic en;
      logic rw;
      logic done;
      logic rdy;
      logic ovf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [CW-1:0] a_val;
   logic [CW-1:0] b_val;
   logic          in_ready;
   logic          hold;
   logic          A;
   logic          B;
   logic          en;
   logic          read_or_write;
   logic          done;
`ifdef UNARY_STREAM_TX_OVF_EN
   logic          ovf;
`endif

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   edges = 0;
   logic m_ovf = 1'b0;

   unary_stream_tx #(.LEN(LEN), .WR_CYCLES(WR)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .a_val         (a_val),
      .b_val         (b_val),
      .in_ready      (in_ready),
      .hold          (hold),
      .A             (A),
      .B             (B),
      .en            (en),
      .read_or_write (read_or_write),
`ifdef UNARY_STREAM_TX_OVF_EN
      .done          (done),
      .ovf           (ovf)
`else
      .done          (done)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   // Monitor: compare one expected word per cycle, away from the rising edge
   always @(negedge clk) begin
      exp_t e;
      exp_t g;
      if (edges > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g.a    = A;
         g.b    = B;
         g.en   = en;
         g.rw   = read_or_write;
         g.done = done;
         g.rdy  = in_ready;
`ifdef UNARY_STREAM_TX_OVF_EN
         g.ovf  = ovf;
`else
         g.ovf  = 1'b0;
         e.ovf  = 1'b0;
`endif
         n_vec = n_vec + 1;
         if (g !== e) begin
            n_bad = n_bad + 1;
            $display("FAIL frame_out t=%0t got A=%b B=%b en=%b rw=%b done=%b rdy=%b ovf=%b want A=%b B=%b en=%b rw=%b done=%b rdy=%b ovf=%b",
                     $time, g.a, g.b, g.en, g.rw, g.done, g.rdy, g.ovf,
                     e.a, e.b, e.en, e.rw, e.done, e.rdy, e.ovf);
         end
      end
   end

   function automatic exp_t mk(input logic a, input logic b, input logic e,
                               input logic rw, input logic dn, input logic rdy);
      exp_t r;
      r.a = a; r.b = b; r.en = e; r.rw = rw; r.done = dn; r.rdy = rdy;
      r.ovf = m_ovf;
      return r;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [CW-1:0] rop();
      return CW'($urandom_range(0, (1 << CW) - 1));
   endfunction

   // Apply one cycle of inputs and record what must appear after the edge
   task automatic drive_cycle(input logic r, input logic iv, input logic h,
                              input logic [CW-1:0] av, input logic [CW-1:0] bv,
                              input exp_t e);
      rst      = r;
      in_valid = iv;
      hold     = h;
      a_val    = av;
      b_val    = bv;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      drive_cycle(1'b0, 1'b0, rbit(), rop(), rop(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
   endtask

   // One frame: accept (av,bv); optional directed stall of st_len cycles
   // before bit st_at; optional random stalls; optional reset at frame
   // cycle abort_at; iv_hi keeps in_valid high throughout.
   task automatic run_frame(input int av, input int bv, input int st_at, input int st_len,
                            input int abort_at, input bit iv_hi, input bit rnd_stall);
      exp_t seq[$];
      logic hq[$];
      int   sa;
      int   sb;
      int   n;
      m_ovf = (av > LEN) || (bv > LEN);
      sa = (av > LEN) ? LEN : av;
      sb = (bv > LEN) ? LEN : bv;
      seq.push_back(mk(0 < sa, 0 < sb, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int k = 1; k < LEN; k++) begin
         int ns;
         ns = (k == st_at) ? st_len : 0;
         if (rnd_stall && $urandom_range(0, 5) == 0) ns = $urandom_range(1, 3);
         for (int s = 0; s < ns; s++) begin
            hq.push_back(1'b1);
            seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         end
         hq.push_back(1'b0);
         seq.push_back(mk(k < sa, k < sb, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      hq.push_back(1'b0);
      seq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      for (int w = 1; w < WR; w++) begin
         hq.push_back(rbit());
         seq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      end
      hq.push_back(rbit());
      seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      hq.push_back(rbit());
      drive_cycle(1'b0, 1'b1, rbit(), CW'(av), CW'(bv), seq[0]);
      n = seq.size();
      for (int c = 0; c < n; c++) begin
         if (c == abort_at) begin
            m_ovf = 1'b0;
            drive_cycle(1'b1, 1'b1, rbit(), rop(), rop(),
                        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            return;
         end
         drive_cycle(1'b0, iv_hi ? 1'b1 : rbit(), hq[c], rop(), rop(),
                     (c < n - 1) ? seq[c + 1] : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      hold     = 1'b0;
      a_val    = {CW{1'b0}};
      b_val    = {CW{1'b0}};
      // Reset with in_valid high: nothing may be captured.
      for (int i = 0; i < 3; i++)
         drive_cycle(1'b1, 1'b1, 1'b0, CW'(5), CW'(3), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      idle_cycle();
      // Directed frames.
      run_frame(5, 3, -1, 0, -1, 1'b0, 1'b0);
      idle_cycle();
      run_frame(0, 16, -1, 0, -1, 1'b0, 1'b0);
      run_frame(16, 0, -1, 0, -1, 1'b0, 1'b0);
      run_frame(20, 7, -1, 0, -1, 1'b0, 1'b0);
      idle_cycle();
      run_frame(9, 9, 4, 3, -1, 1'b0, 1'b0);
      // Reset mid-stream, then accept on the very next cycle.
      run_frame(12, 6, -1, 0, 10, 1'b0, 1'b0);
      run_frame(7, 11, -1, 0, -1, 1'b0, 1'b0);
      // in_valid held high across back-to-back frames.
      run_frame(3, 14, -1, 0, -1, 1'b1, 1'b0);
      run_frame(31, 1, -1, 0, -1, 1'b1, 1'b0);
      // Reset mid-write.
      run_frame(8, 8, -1, 0, 30, 1'b1, 1'b0);
      // Randomized frames.
      for (int i = 0; i < 20; i++) begin
         int gap;
         int ab;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_cycle();
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 45) : -1;
         run_frame($urandom_range(0, (1 << CW) - 1), $urandom_range(0, (1 << CW) - 1),
                   -1, 0, ab, rbit(), 1'b1);
      end
      idle_cycle();
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_bad = n_bad + 1;
         $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/unary_stream_tx.md
UNARY_STREAM_TX -- requirements
Module: unary_stream_tx

Interface
REQ-001 The module SHALL have parameter LEN, default 16, meaning unary stream length in cycles (operand range 0..LEN).
REQ-002 The module SHALL have parameter WR_CYCLES, default 32, meaning the number of write-phase (read_or_write=1) cycles issued after streaming.
REQ-003 The module SHALL have localparam CW = clog2(LEN+1), meaning operand width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-007 The module SHALL have port a_val, input, CW bits: binary count for stream A.
REQ-008 The module SHALL have port b_val, input, CW bits: binary count for stream B.
REQ-009 The module SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-010 The module SHALL have port hold, input, 1 bit: stall request during STREAM.
REQ-011 The module SHALL have ports A and B, output, 1 bit each: thermometer-coded streams.
REQ-012 The module SHALL have ports en and read_or_write, output, 1 bit each: adder enable and phase select.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, STREAM, WRITE and DONE.
REQ-015 IDLE: in_valid&&in_ready captures a_val/b_val into a_q/b_q, clears idx, and moves to STREAM; otherwise the FSM stays in IDLE.
REQ-016 STREAM: per cycle with hold=0, en=1, read_or_write=0, A=(idx<a_q), B=(idx<b_q), and idx increments; after idx reaches LEN-1, the FSM moves to WRITE.
REQ-017 STREAM with hold=1: en=0, A=0, B=0, idx frozen; no stream bit is lost or duplicated, and the stall length is unbounded.
REQ-018 All outputs except in_ready SHALL be registered; the first stream bit appears on the cycle after the accepting edge (latency 1).
REQ-019 Operand values above LEN SHALL produce LEN ones, i.e. saturate.
REQ-020 Operand value 0 SHALL produce an all-zero stream.
REQ-021 Operand value LEN SHALL produce all ones.
REQ-022 WRITE: en=1, read_or_write=1, A=B=0 for exactly WR_CYCLES cycles; hold is ignored; then the FSM moves to DONE.
REQ-023 DONE: done=1, en=0, read_or_write=0, in_ready=0 for one cycle; then the FSM moves to IDLE.
REQ-024 Total frame length with no stall SHALL be LEN+WR_CYCLES+1 cycles from first stream bit to the done pulse inclusive.
REQ-025 in_valid outside IDLE SHALL be ignored; a new operand pair is never captured mid-frame.
REQ-026 Each A/B stream SHALL contain exactly min(val,LEN) ones, contiguous from the first bit.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be IDLE, with A=0, B=0, en=0, read_or_write=0, done=0, idx=0, a_q=0 and b_q=0.
REQ-028 in_ready SHALL read 1 after reset, because it is decoded from IDLE.
REQ-029 Reset asserted mid-STREAM or mid-WRITE SHALL abort the frame with no done pulse.
REQ-030 in_valid SHALL be ignored in any cycle where rst=1.

Configuration
REQ-031 Macro UNARY_STREAM_TX_OVF_EN defined: the block SHALL add output port ovf (1 bit), which is registered at capture, equals (a_val>LEN)||(b_val>LEN), holds until the next capture, and resets to 0.
REQ-032 Macro UNARY_STREAM_TX_OVF_EN undefined: the ovf port and its logic SHALL be absent, and saturation behaviour is unchanged.

Structure
REQ-033 The shared package unary_pkg SHALL hold the FSM state enum and the default LEN/WR_CYCLES constants.
REQ-034 A single sub-module unary_therm_bit SHALL be used, instantiated twice (for A and B): a comparator (idx<val) with saturation.
REQ-035 The FSM, idx counter and operand registers SHALL reside in the top module.

Verification
REQ-036 Reset with a=5, b=3: stream A=1111100000000000, stream B=1110000000000000, then 32 cycles with read_or_write=1, then done pulses once.
REQ-037 a=0, b=16 -> A all zero for 16 cycles and B all ones for 16 cycles; a=16, b=0 mirrored.
REQ-038 a=20, b=7 -> A is 16 ones; with UNARY_STREAM_TX_OVF_EN defined, ovf=1 from the cycle after capture.
REQ-039 a=9, b=9 with hold asserted for 3 cycles at idx=4 -> en low 3 cycles, exactly 9 ones on each stream, and frame extended by 3 cycles.
REQ-040 rst pulsed at idx=10 -> all outputs are 0 the next cycle, there is no done pulse, in_ready=1, and a new pair is accepted the following cycle.
REQ-041 in_valid held high continuously -> exactly one capture per frame, and the next capture occurs on the cycle after the done pulse.
